calculator_ops: RTL and testbench
=================================

# calculator_ops

Parametrised multi-operation accumulator calculator, W-bit, with a ready handshake. An internal accumulator is loaded from `in` and combined with later operands by add, subtract, AND or multi-cycle shift-add multiply. It sits behind switch/button front-ends as the arithmetic core of the board-level calculator design. It adds an operation select, an overflow flag and multi-cycle busy behaviour.

## Interface
- `W`, default 8: data width in bits (W ≥ 2).
- `clk`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `load`  input  1  accumulator ← `in`; sampled on the rising edge while `ready`=1.
- `calc`  input  1  accumulator ← accumulator `op` `in`; sampled on the rising edge while `ready`=1.
- `op`  input  2  operation: 00 add, 01 sub, 10 mul, 11 and.
- `in`  input  W  operand / load value.
- `ready`  output  1  1 = idle, accepting commands; 0 = multiply in progress.
- `out`  output  W  accumulator value (registered).
- `ovf`  output  1  overflow/borrow flag of the last `calc` (registered).

## Operation
- States: IDLE, MUL. `ready` = (state == IDLE), decoded from the state register.
- IDLE, `load`=1: `out` ← `in`, `ovf` ← 0. `load` has priority over `calc` when both are 1.
- IDLE, `calc`=1 with `op`=00: `out` ← (A+in) mod 2^W; `ovf` ← carry out.
- IDLE, `calc`=1 with `op`=01: `out` ← (A−in) mod 2^W; `ovf` ← 1 iff A < in (unsigned).
- IDLE, `calc`=1 with `op`=11: `out` ← A & in; `ovf` ← 0.
- IDLE, `calc`=1 with `op`=10:
  - Internal regs: M (2W bits) ← {0,A}, Q ← `in`, P (2W bits) ← 0, cnt ← W.
  - State → MUL.
- MUL, each cycle:
  - If Q[0], P ← P+M.
  - M ← M<<1; Q ← Q>>1; cnt ← cnt−1.
  - On the cycle with cnt==1:
    - `out` ← low W bits of the final P.
    - `ovf` ← 1 iff the high W bits of the final P are non-zero.
    - State → IDLE.
- MUL: `load`, `calc`, `op` and `in` are ignored; they are not queued. `out` and `ovf` hold their previous values until completion.
- All arithmetic is unsigned. No intermediate wider than 2W. cnt width is $clog2(W+1).
- IDLE with neither command: all registers hold.

## Timing
- Reset (asynchronous, any state, including mid-multiply):
  - Effect is immediate: state=IDLE, `out`=0, `ovf`=0, `ready`=1, and M/Q/P/cnt cleared.
  - Commands are accepted from the first rising edge after `reset` deasserts.
- Load/add/sub/and: 1-cycle latency. Result is visible after the sampling edge; `ready` stays 1, so back-to-back commands are possible every cycle.
- Multiply accepted at edge k:
  - `ready`=0 from edge k to edge k+W, exactly W cycles.
  - `out`/`ovf` update and `ready` returns to 1 at edge k+W.
  - A new command is accepted at edge k+W+1.
- A command present on the same edge where MUL completes is ignored, because `ready` was 0 when it was sampled.

## Configuration
- Macro: `CALC_MUL_EN`.
- Defined: the multiplier (M, Q, P, cnt, MUL state) is built as described above.
- Undefined:
  - No multiplier logic and no MUL state; `ready` is tied to 1.
  - `calc` with `op`=10 is a single-cycle no-op: `out` holds and `ovf` ← 0.

## Test plan
All scenarios use W=8.
- Reset: assert `reset` asynchronously between clock edges → `out`=0, `ovf`=0 and `ready`=1 without waiting for an edge.
- Add/sub chain: load 200; calc add 100 → `out`=44, `ovf`=1. Then calc sub 50 → `out`=250, `ovf`=1. Then calc sub 250 → `out`=0, `ovf`=0. Each result lands one cycle after its command.
- Multiply (macro defined):
  - load 12; calc mul 11 → `ready`=0 for exactly 8 cycles, then `out`=132, `ovf`=0.
  - load 20; calc mul 13 → `out`=4, `ovf`=1.
- Busy and priority:
  - During a multiply, pulse `load` with `in`=5 → ignored; the product is unchanged.
  - In IDLE, assert `load`=1 and `calc`=1 together with `in`=7 → `out`=7, `ovf`=0.
- AND: load 8'hF0; calc and 8'h3C → `out`=8'h30, `ovf`=0.
- Reset mid-multiply: assert `reset` 3 cycles into a multiply → `out`=0, `ready`=1 immediately. After release, a normal add (`out`=0 plus `in`) works.
- Macro undefined: load 9; calc mul 3 → `out`=9, `ovf`=0, and `ready` never drops.

Source files
------------

// File: rtl/calculator_ops.sv
// ============================================================================
// Module      : calculator_ops
// Description : W-bit accumulator calculator (add/sub/and, shift-add multiply)
//               with ready handshake and overflow flag. Multiplier is built
//               only when CALC_MUL_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module calculator_ops #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         calc,
    input  logic [1:0]   op,
    input  logic [W-1:0] in,
    output logic         ready,
    output logic [W-1:0] out,
    output logic         ovf
);

    localparam logic [1:0] c_OP_ADD = 2'b00;
    localparam logic [1:0] c_OP_SUB = 2'b01;
    localparam logic [1:0] c_OP_AND = 2'b11;

    logic [W-1:0] r_out;
    logic         r_ovf;
    logic [W:0]   w_sum;
    logic [W:0]   w_diff;
    logic [W-1:0] w_cmd_out;
    logic         w_cmd_ovf;
`ifdef CALC_MUL_EN
    logic         w_cmd_mul;
`endif

    assign out    = r_out;
    assign ovf    = r_ovf;
    assign w_sum  = {1'b0, r_out} + {1'b0, in};
    // MSB of the widened difference is the borrow (A < in)
    assign w_diff = {1'b0, r_out} - {1'b0, in};

    // Result of a single-cycle command as it would be applied in IDLE
    always_comb begin
        w_cmd_out = r_out;
        w_cmd_ovf = r_ovf;
`ifdef CALC_MUL_EN
        w_cmd_mul = 1'b0;
`endif
        if (load) begin
            w_cmd_out = in;
            w_cmd_ovf = 1'b0;
        end else if (calc) begin
            case (op)
                c_OP_ADD: begin
                    w_cmd_out = w_sum[W-1:0];
                    w_cmd_ovf = w_sum[W];
                end
                c_OP_SUB: begin
                    w_cmd_out = w_diff[W-1:0];
                    w_cmd_ovf = w_diff[W];
                end
                c_OP_AND: begin
                    w_cmd_out = r_out & in;
                    w_cmd_ovf = 1'b0;
                end
                default: begin
`ifdef CALC_MUL_EN
                    w_cmd_mul = 1'b1;
`else
                    w_cmd_ovf = 1'b0;
`endif
                end
            endcase
        end
    end

`ifdef CALC_MUL_EN
    localparam int CW = $clog2(W + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t         r_state, w_state_nxt;
    logic [2*W-1:0] r_m, w_m_nxt;
    logic [2*W-1:0] r_p, w_p_nxt, w_p_acc;
    logic [W-1:0]   r_q, w_q_nxt;
    logic [CW-1:0]  r_cnt, w_cnt_nxt;
    logic [W-1:0]   w_out_nxt;
    logic           w_ovf_nxt;

    assign ready   = (r_state == S_IDLE);
    assign w_p_acc = r_q[0] ? (r_p + r_m) : r_p;

    always_comb begin
        w_state_nxt = r_state;
        w_m_nxt     = r_m;
        w_p_nxt     = r_p;
        w_q_nxt     = r_q;
        w_cnt_nxt   = r_cnt;
        w_out_nxt   = r_out;
        w_ovf_nxt   = r_ovf;
        case (r_state)
            S_IDLE: begin
                w_out_nxt = w_cmd_out;
                w_ovf_nxt = w_cmd_ovf;
                if (w_cmd_mul) begin
                    w_m_nxt     = {{W{1'b0}}, r_out};
                    w_q_nxt     = in;
                    w_p_nxt     = '0;
                    w_cnt_nxt   = CW'(W);
                    w_state_nxt = S_MUL;
                end
            end
            S_MUL: begin
                w_p_nxt   = w_p_acc;
                w_m_nxt   = r_m << 1;
                w_q_nxt   = r_q >> 1;
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt == CW'(1)) begin
                    w_out_nxt   = w_p_acc[W-1:0];
                    w_ovf_nxt   = |w_p_acc[2*W-1:W];
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_m     <= '0;
            r_p     <= '0;
            r_q     <= '0;
            r_cnt   <= '0;
            r_out   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_m     <= w_m_nxt;
            r_p     <= w_p_nxt;
            r_q     <= w_q_nxt;
            r_cnt   <= w_cnt_nxt;
            r_out   <= w_out_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end
`else
    assign ready = 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_out <= w_cmd_out;
            r_ovf <= w_cmd_ovf;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_calculator_ops.sv
// ============================================================================
// Module      : tb_calculator_ops
// Description : Self-checking bench for calculator_ops (W=8), directed plus
//               randomized commands against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_calculator_ops;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         load;
    logic         calc;
    logic [1:0]   op;
    logic [W-1:0] d_in;
    logic         ready;
    logic [W-1:0] out_v;
    logic         ovf;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] ref_acc;
    logic         ref_ovf;

    calculator_ops #(.W(W)) u_dut (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .calc  (calc),
        .op    (op),
        .in    (d_in),
        .ready (ready),
        .out   (out_v),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Apply one command at the next edge, then check the resulting state
    task automatic run_cmd(input logic l, input logic c, input logic [1:0] o, input logic [W-1:0] v);
        bit          is_mul;
        int unsigned prod;
        load = l; calc = c; op = o; d_in = v;
        @(posedge clk); #1;
        load = 1'b0; calc = 1'b0;
        is_mul = !l && c && (o == 2'b10);
        prod   = ref_acc * v;
`ifdef CALC_MUL_EN
        if (is_mul) begin
            check_eq("mul_busy_start", ready, 0);
            for (int i = 1; i <= W; i++) begin
                load = 1'($urandom); calc = 1'($urandom);
                op = 2'($urandom); d_in = W'($urandom);
                @(posedge clk); #1;
                if (i < W) begin
                    check_eq("mul_busy", ready, 0);
                    check_eq("mul_out_hold", out_v, ref_acc);
                end
            end
            load = 1'b0; calc = 1'b0;
            ref_acc = prod[W-1:0];
            ref_ovf = (prod >> W) != 0;
            check_eq("mul_ready_back", ready, 1);
            check_eq("mul_out", out_v, ref_acc);
            check_eq("mul_ovf", ovf, ref_ovf);
            return;
        end
`endif
        if (l) begin
            ref_acc = v; ref_ovf = 1'b0;
        end else if (c) begin
            case (o)
                2'b00: begin
                    ref_ovf = (int'(ref_acc) + int'(v)) > (2**W - 1);
                    ref_acc = W'(int'(ref_acc) + int'(v));
                end
                2'b01: begin
                    ref_ovf = ref_acc < v;
                    ref_acc = W'(int'(ref_acc) - int'(v));
                end
                2'b11: begin
                    ref_acc = ref_acc & v; ref_ovf = 1'b0;
                end
                default: ref_ovf = 1'b0;
            endcase
        end
        check_eq("cmd_ready", ready, 1);
        check_eq("cmd_out", out_v, ref_acc);
        check_eq("cmd_ovf", ovf, ref_ovf);
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; calc = 1'b0; op = 2'b00; d_in = '0;
        ref_acc = '0; ref_ovf = 1'b0;
        #12;
        check_eq("rst_out", out_v, 0);
        check_eq("rst_ovf", ovf, 0);
        check_eq("rst_ready", ready, 1);
        @(negedge clk); reset = 1'b0;

        // Add/sub chain
        run_cmd(1'b1, 1'b0, 2'b00, 8'd200);
        run_cmd(1'b0, 1'b1, 2'b00, 8'd100);
        check_eq("add_44", out_v, 44);
        check_eq("add_carry", ovf, 1);
        run_cmd(1'b0, 1'b1, 2'b01, 8'd50);
        check_eq("sub_250", out_v, 250);
        check_eq("sub_borrow", ovf, 1);
        run_cmd(1'b0, 1'b1, 2'b01, 8'd250);
        check_eq("sub_0", out_v, 0);
        check_eq("sub_noborrow", ovf, 0);

        // Priority and AND
        run_cmd(1'b1, 1'b1, 2'b10, 8'd7);
        check_eq("prio_out", out_v, 7);
        check_eq("prio_ovf", ovf, 0);
        run_cmd(1'b1, 1'b0, 2'b00, 8'hF0);
        run_cmd(1'b0, 1'b1, 2'b11, 8'h3C);
        check_eq("and_out", out_v, 8'h30);
        check_eq("and_ovf", ovf, 0);

`ifdef CALC_MUL_EN
        run_cmd(1'b1, 1'b0, 2'b00, 8'd12);
        run_cmd(1'b0, 1'b1, 2'b10, 8'd11);
        check_eq("mul_132", out_v, 132);
        check_eq("mul_132_ovf", ovf, 0);
        run_cmd(1'b1, 1'b0, 2'b00, 8'd20);
        run_cmd(1'b0, 1'b1, 2'b10, 8'd13);
        check_eq("mul_260", out_v, 4);
        check_eq("mul_260_ovf", ovf, 1);

        // Reset three cycles into a multiply
        run_cmd(1'b1, 1'b0, 2'b00, 8'd99);
        calc = 1'b1; op = 2'b10; d_in = 8'd77;
        @(posedge clk); #1; calc = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check_eq("rst_mid_out", out_v, 0);
        check_eq("rst_mid_ovf", ovf, 0);
        check_eq("rst_mid_ready", ready, 1);
        #1 reset = 1'b0;
        ref_acc = '0; ref_ovf = 1'b0;
        run_cmd(1'b0, 1'b1, 2'b00, 8'd37);
        check_eq("post_rst_add", out_v, 37);
`else
        run_cmd(1'b1, 1'b0, 2'b00, 8'd9);
        run_cmd(1'b0, 1'b1, 2'b10, 8'd3);
        check_eq("nomul_out", out_v, 9);
        check_eq("nomul_ovf", ovf, 0);
        check_eq("nomul_ready", ready, 1);
`endif

        // Asynchronous reset between edges, no clock edge in between
        run_cmd(1'b1, 1'b0, 2'b00, 8'd77);
        #2 reset = 1'b1;
        #1;
        check_eq("async_rst_out", out_v, 0);
        check_eq("async_rst_ready", ready, 1);
        #1 reset = 1'b0;
        ref_acc = '0; ref_ovf = 1'b0;

        // Randomized command mix
        for (int i = 0; i < 150; i++) begin
            logic       rl, rc;
            logic [1:0] ro;
            rl = ($urandom_range(0, 3) == 0);
            rc = ($urandom_range(0, 4) != 0);
            ro = 2'($urandom);
            run_cmd(rl, rc, ro, W'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
